dm_sba_ctrl: RTL

Parametrised System Bus Access (SBA) master for the debug module, the successor to the fixed 32-bit SBA state machine. It owns the `sbcs`, `sbaddress0/1` and `sbdata0/1` register state, decodes DMI-side register accesses into single-beat bus transactions, and drives a req/gnt/rvalid bus master port. The bus width is 32 or 64 bits, with byte-lane steering, auto-increment, read-on-address, read-on-data and full error and busy-error reporting per debug spec 0.13.

---
 rtl/dm_sba_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dm_sba_ctrl.sv
// dm_sba_ctrl: debug-module System Bus Access master.
//
// Holds the sbcs, sbaddress and sbdata register state, turns DMI-side register
// accesses into single-beat bus transactions and drives a req/gnt/rvalid master
// port. The bus is BusWidth (32 or 64) bits wide, with byte-lane steering,
// auto-increment, read-on-address, read-on-data and error/busy-error reporting.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   dmactive_i           low: synchronously clear all register state
//   sbcs_we_i            DMI write of sbcs
//   sbaddress_we_i       DMI write of sbaddress (full BusWidth word)
//   sbdata_we_i          DMI write of sbdata (full BusWidth word)
//   sbdata_re_i          DMI read of sbdata0 consumed this cycle
//   wdata_dmi_i          DMI write data
//   sbcs_o               current sbcs value
//   sbaddress_o          current address register
//   sbdata_o             current data register
//   req_o, we_o          bus request, 1 = write
//   addr_o, wdata_o      bus address, lane-steered write data
//   be_o                 byte enables
//   gnt_i                bus grant
//   rvalid_i, rdata_i    response valid, read data
//   err_i                bus error, qualified by rvalid_i
module dm_sba_ctrl #(
  parameter int unsigned BusWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  input  logic                  sbcs_we_i,
  input  logic                  sbaddress_we_i,
  input  logic                  sbdata_we_i,
  input  logic                  sbdata_re_i,
  input  logic [BusWidth-1:0]   wdata_dmi_i,
  output logic [31:0]           sbcs_o,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  req_o,
  output logic                  we_o,
  output logic [BusWidth-1:0]   addr_o,
  output logic [BusWidth-1:0]   wdata_o,
  output logic [BusWidth/8-1:0] be_o,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic [BusWidth-1:0]   rdata_i,
  input  logic                  err_i
);

  localparam int unsigned BeW       = BusWidth / 8;
  localparam int unsigned OffW      = $clog2(BeW);
  localparam logic [2:0]  MaxAccess = 3'(OffW);
  localparam logic        Access64  = (BusWidth == 64);

  // sba_state_e
  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StRead      = 3'd1;
  localparam logic [2:0] StWrite     = 3'd2;
  localparam logic [2:0] StWaitRead  = 3'd3;
  localparam logic [2:0] StWaitWrite = 3'd4;

  localparam logic [2:0] ErrNone    = 3'd0;
  localparam logic [2:0] ErrAlign   = 3'd3;
  localparam logic [2:0] ErrBadSize = 3'd4;
  localparam logic [2:0] ErrBus     = 3'd7;

  localparam logic [2:0] AccessRst = 3'd2;

  // Byte enables for a (1 << access)-byte access at byte offset off.
  function automatic logic [BeW-1:0] lane_be(input logic [2:0]      access,
                                             input logic [OffW-1:0] off);
    logic [BeW-1:0] mask;
    for (int i = 0; i < BeW; i++) begin
      mask[i] = (i < (1 << access));
    end
    return mask << off;
  endfunction

  // Move the addressed lanes down to bit 0 and zero everything above the size.
  function automatic logic [BusWidth-1:0] lane_rdata(input logic [BusWidth-1:0] rdata,
                                                     input logic [2:0]          access,
                                                     input logic [OffW-1:0]     off);
    logic [BusWidth-1:0] shifted;
    shifted = rdata >> {off, 3'b000};
    for (int i = 0; i < BeW; i++) begin
      if (i >= (1 << access)) begin
        shifted[8*i +: 8] = 8'h00;
      end
    end
    return shifted;
  endfunction

  // Any offset bit below the access size makes the address unaligned.
  function automatic logic misaligned(input logic [2:0]      access,
                                      input logic [OffW-1:0] off);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < OffW; i++) begin
      if ((i < (1 << 0) * 32'(access)) && off[i]) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  // Bus-side state
  logic [2:0]          state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [BusWidth-1:0] addr_q, addr_d;
  logic [BusWidth-1:0] wdata_q, wdata_d;
  logic [BeW-1:0]      be_q, be_d;
  logic [2:0]          txn_access_q, txn_access_d;
  logic                discard_q, discard_d;

  // Register state
  logic [BusWidth-1:0] sbaddress_q, sbaddress_d;
  logic [BusWidth-1:0] sbdata_q, sbdata_d;
  logic                rdonaddr_q, rdonaddr_d;
  logic [2:0]          access_q, access_d;
  logic                autoinc_q, autoinc_d;
  logic                rdondata_q, rdondata_d;
  logic                busyerr_q, busyerr_d;
  logic [2:0]          sberror_q, sberror_d;

  logic                busy;
  logic                done;
  logic                discard_now;
  logic                start;
  logic                start_we;
  logic [BusWidth-1:0] start_addr;
  logic [BusWidth-1:0] start_data;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    txn_access_d = txn_access_q;
    sbaddress_d  = sbaddress_q;
    sbdata_d     = sbdata_q;
    rdonaddr_d   = rdonaddr_q;
    access_d     = access_q;
    autoinc_d    = autoinc_q;
    rdondata_d   = rdondata_q;
    busyerr_d    = busyerr_q;
    sberror_d    = sberror_q;
    start        = 1'b0;
    start_we     = 1'b0;
    start_addr   = sbaddress_q;
    start_data   = sbdata_q;
    done         = 1'b0;
    busy         = (state_q != StIdle);

    case (state_q)
      StRead, StWrite: begin
        if (gnt_i) begin
          req_d   = 1'b0;
          state_d = (state_q == StRead) ? StWaitRead : StWaitWrite;
        end
      end
      StWaitRead, StWaitWrite: begin
        if (rvalid_i) begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: ;
    endcase

    // A transaction in flight when dmactive drops still completes its handshake,
    // but its outcome must never reach the (freshly cleared) registers.
    discard_now = discard_q | ~dmactive_i;
    discard_d   = busy & (state_d != StIdle) & discard_now;

    if (dmactive_i) begin
      if (sbcs_we_i) begin
        busyerr_d  = busyerr_q & ~wdata_dmi_i[22];
        rdonaddr_d = wdata_dmi_i[20];
        access_d   = wdata_dmi_i[19:17];
        autoinc_d  = wdata_dmi_i[16];
        rdondata_d = wdata_dmi_i[15];
        sberror_d  = sberror_q & ~wdata_dmi_i[14:12];
      end else if (sbaddress_we_i) begin
        if (busy) begin
          busyerr_d = 1'b1;
        end else begin
          sbaddress_d = wdata_dmi_i;
          start       = rdonaddr_q;
          start_addr  = wdata_dmi_i;
        end
      end else if (sbdata_we_i) begin
        if (busy) begin
          busyerr_d = 1'b1;
        end else begin
          sbdata_d   = wdata_dmi_i;
          start      = 1'b1;
          start_we   = 1'b1;
          start_data = wdata_dmi_i;
        end
      end else if (sbdata_re_i) begin
        if (busy) begin
          busyerr_d = 1'b1;
        end else begin
          start = rdondata_q;
        end
      end

      if (start && (sberror_q == ErrNone) && !busyerr_q) begin
        if (access_q > MaxAccess) begin
          sberror_d = ErrBadSize;
        end else if (misaligned(access_q, start_addr[OffW-1:0])) begin
          sberror_d = ErrAlign;
        end else begin
          state_d      = start_we ? StWrite : StRead;
          req_d        = 1'b1;
          we_d         = start_we;
          addr_d       = start_addr;
          wdata_d      = start_data << {start_addr[OffW-1:0], 3'b000};
          be_d         = lane_be(access_q, start_addr[OffW-1:0]);
          txn_access_d = access_q;
        end
      end

      // Evaluated after the sbcs write so a completion error beats a W1C clear.
      if (done && !discard_now) begin
        if (err_i) begin
          sberror_d = ErrBus;
        end else begin
          if (state_q == StWaitRead) begin
            sbdata_d = lane_rdata(rdata_i, txn_access_q, addr_q[OffW-1:0]);
          end
          if (autoinc_q) begin
            sbaddress_d = sbaddress_q + (BusWidth'(1) << txn_access_q);
          end
        end
      end
    end else begin
      sbaddress_d = '0;
      sbdata_d    = '0;
      rdonaddr_d  = 1'b0;
      access_d    = AccessRst;
      autoinc_d   = 1'b0;
      rdondata_d  = 1'b0;
      busyerr_d   = 1'b0;
      sberror_d   = ErrNone;
      // Bus outputs must stay stable until the outstanding handshake is done.
      if (!busy) begin
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        be_d    = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      txn_access_q <= AccessRst;
      discard_q    <= 1'b0;
      sbaddress_q  <= '0;
      sbdata_q     <= '0;
      rdonaddr_q   <= 1'b0;
      access_q     <= AccessRst;
      autoinc_q    <= 1'b0;
      rdondata_q   <= 1'b0;
      busyerr_q    <= 1'b0;
      sberror_q    <= ErrNone;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      txn_access_q <= txn_access_d;
      discard_q    <= discard_d;
      sbaddress_q  <= sbaddress_d;
      sbdata_q     <= sbdata_d;
      rdonaddr_q   <= rdonaddr_d;
      access_q     <= access_d;
      autoinc_q    <= autoinc_d;
      rdondata_q   <= rdondata_d;
      busyerr_q    <= busyerr_d;
      sberror_q    <= sberror_d;
    end
  end

  assign sbcs_o = {3'd1, 6'd0, busyerr_q, busy, rdonaddr_q, access_q, autoinc_q, rdondata_q,
                   sberror_q, 7'(BusWidth), 1'b0, Access64, 3'b111};

  assign sbaddress_o = sbaddress_q;
  assign sbdata_o    = sbdata_q;
  assign req_o       = req_q;
  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign be_o        = be_q;

endmodule
